// File: rtl/fft_agu.sv
// Address generator and sequencer for an in-place radix-2 FFT: operand, twiddle and write-back addressing.
// Optional FFT_AGU_STALL_EN adds a stall input that freezes the sequence and masks we.
module fft_agu #(
    parameter int unsigned L      = 5,
    parameter int unsigned RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
`ifdef FFT_AGU_STALL_EN
    input  logic           stall,
`endif
    output logic [L-1:0]   adr_a,
    output logic [L-1:0]   adr_b,
    output logic [L-2:0]   twiddle_adr,
    output logic           rd_bank,
    output logic [L-1:0]   wr_adr_a,
    output logic [L-1:0]   wr_adr_b,
    output logic           wr_bank,
    output logic           we,
    output logic           busy,
    output logic           done,
    output logic           result_bank
);

    localparam int unsigned I_W = L - 1;
    localparam int unsigned S_W = (L > 2) ? $clog2(L) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     state, state_nxt;
    logic [S_W-1:0] s_q, s_nxt;
    logic [I_W-1:0] i_q, i_nxt;
    logic           rd_vld;
    logic           hold_c;
    logic           pend_c;

    logic [L-1:0]   pa [RD_LAT];
    logic [L-1:0]   pb [RD_LAT];
    logic           pk [RD_LAT];
    logic           pv [RD_LAT];

`ifdef FFT_AGU_STALL_EN
    assign hold_c = stall & ((state == S_RUN) | (state == S_DRAIN));
`else
    assign hold_c = 1'b0;
`endif

    function automatic logic [L-1:0] rotl(input logic [L-1:0] x, input logic [S_W-1:0] sh);
        logic [2*L-1:0] t;
        t = {x, x} << sh;
        return t[2*L-1:L];
    endfunction

    // Valid writes still queued ahead of the last pipeline stage
    always_comb begin
        pend_c = 1'b0;
        for (int k = 0; k < int'(RD_LAT) - 1; k++) begin
            pend_c = pend_c | pv[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            s_q   <= '0;
            i_q   <= '0;
        end else begin
            state <= state_nxt;
            s_q   <= s_nxt;
            i_q   <= i_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        i_nxt     = i_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    s_nxt     = '0;
                    i_nxt     = '0;
                end
            end
            S_RUN: begin
                if (!hold_c) begin
                    if (i_q == {I_W{1'b1}}) begin
                        i_nxt = '0;
                        if (s_q == S_W'(L - 1)) begin
                            state_nxt = S_DRAIN;
                        end else begin
                            s_nxt = s_q + 1'b1;
                        end
                    end else begin
                        i_nxt = i_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!hold_c && !pend_c) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read-side outputs are registered from the counter values they will describe
    always_ff @(posedge clk) begin
        if (!reset) begin
            adr_a       <= '0;
            adr_b       <= '0;
            twiddle_adr <= '0;
            rd_bank     <= 1'b0;
            rd_vld      <= 1'b0;
        end else if (!hold_c) begin
            if (state_nxt == S_RUN) begin
                adr_a       <= rotl({i_nxt, 1'b0}, s_nxt);
                adr_b       <= rotl({i_nxt, 1'b1}, s_nxt);
                twiddle_adr <= i_nxt & ({I_W{1'b1}} << (S_W'(L - 1) - s_nxt));
                rd_bank     <= s_nxt[0];
                rd_vld      <= 1'b1;
            end else begin
                adr_a       <= '0;
                adr_b       <= '0;
                twiddle_adr <= '0;
                rd_bank     <= 1'b0;
                rd_vld      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN) | (state_nxt == S_DRAIN);
            done <= (state_nxt == S_DONE);
        end
    end

    // Write-back pipeline aligns read addresses with butterfly results
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < int'(RD_LAT); k++) begin
                pa[k] <= '0;
                pb[k] <= '0;
                pk[k] <= 1'b0;
                pv[k] <= 1'b0;
            end
        end else if (!hold_c) begin
            pa[0] <= adr_a;
            pb[0] <= adr_b;
            pk[0] <= rd_vld & ~rd_bank;
            pv[0] <= rd_vld;
            for (int k = 1; k < int'(RD_LAT); k++) begin
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
                pk[k] <= pk[k-1];
                pv[k] <= pv[k-1];
            end
        end
    end

    assign wr_adr_a    = pa[RD_LAT-1];
    assign wr_adr_b    = pb[RD_LAT-1];
    assign wr_bank     = pk[RD_LAT-1];
    assign we          = pv[RD_LAT-1] & ~hold_c;
    assign result_bank = 1'(L % 2);

endmodule
